// File: rtl/if_id_buffer_pkg.sv
// rv32i_types: shared IF/ID types (IF request record, fetch FSM states, fetch packet)
package rv32i_types;
  typedef struct packed {
    logic [31:0] pc;
  } if_id_reg_t;
  typedef enum logic [1:0] {FETCH_IDLE, FETCH_WAIT, FETCH_DISCARD} fetch_state_t;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        valid;
  } fetch_pkt_t;
endpackage

// File: rtl/if_id_buffer_skid.sv
// fetch_skid: one-entry fetch_pkt_t holder; ports clk/rst, push d, pop, clear, q
module fetch_skid
  import rv32i_types::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic       clear,
  input  fetch_pkt_t d,
  output fetch_pkt_t q
);
  always_ff @(posedge clk)
    if (rst || clear) q <= '0;
    else if (push) q <= d;
    else if (pop) q.valid <= 1'b0;
endmodule

// File: rtl/if_id_buffer.sv
// if_id_buffer: fetch-response tracker + IF/ID register with skid; in if_id_reg/req_valid/imem_*/id_stall/flush, out if_stall/id_valid/id_pc/id_inst
module if_id_buffer
  import rv32i_types::*;
(
  input  logic        clk,
  input  logic        rst,
  input  if_id_reg_t  if_id_reg,
  input  logic        req_valid,
  input  logic [31:0] imem_rdata,
  input  logic        imem_resp,
  input  logic        id_stall,
  input  logic        flush,
  output logic        if_stall,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst
);
  fetch_state_t state;
  logic [31:0]  pend_pc;
  fetch_pkt_t   out, skid, arr;
  logic         skid_valid, accept, deliver, consume, to_out;
  assign skid_valid = skid.valid;
  assign if_stall = rst | flush | skid_valid | (out.valid & id_stall) |
                    ((state != FETCH_IDLE) & !imem_resp);
  assign accept  = req_valid & !if_stall;
  assign deliver = (state == FETCH_WAIT) & imem_resp & !flush;
  assign consume = out.valid & !id_stall;
  assign to_out  = deliver & (!out.valid | consume) & !skid_valid;
  assign arr     = '{pc: pend_pc, inst: imem_rdata, valid: 1'b1};
  fetch_skid u_skid (
    .clk  (clk),
    .rst  (rst),
    .push (deliver & !to_out),
    .pop  (consume),
    .clear(flush),
    .d    (arr),
    .q    (skid)
  );
  // accept is never high during flush, so a flushed fetch lands in IDLE or DISCARD
  always_ff @(posedge clk)
    if (rst) begin
      state   <= FETCH_IDLE;
      pend_pc <= '0;
      out     <= '0;
    end else begin
      state <= ((state == FETCH_IDLE) | imem_resp) ? (accept ? FETCH_WAIT : FETCH_IDLE)
                                                   : (flush ? FETCH_DISCARD : state);
      if (accept) pend_pc <= if_id_reg.pc;
      if (flush) out.valid <= 1'b0;
      else if (consume && skid_valid) out <= skid;
      else if (to_out) out <= arr;
      else if (consume) out.valid <= 1'b0;
    end
  assign id_valid = out.valid;
  assign id_pc    = out.pc;
  assign id_inst  = out.inst;
endmodule

// File: tb/tb_if_id_buffer.sv
// tb_if_id_buffer: directed stimulus with a queue-based reference model and per-cycle compare
module tb_if_id_buffer;
  import rv32i_types::*;
  logic        clk = 0, rst = 1, req_valid = 0, imem_resp = 0, id_stall = 0, flush = 0;
  if_id_reg_t  if_id_reg = '0;
  logic [31:0] imem_rdata = '0;
  logic        if_stall, id_valid;
  logic [31:0] id_pc, id_inst;
  int          checks = 0, fails = 0;
  logic        st_seen;
  int          cnt;
  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;
  ent_t        q[$];
  bit          m_out = 0, m_disc = 0;
  logic [31:0] m_pc = '0;

  if_id_buffer dut (
    .clk       (clk),
    .rst       (rst),
    .if_id_reg (if_id_reg),
    .req_valid (req_valid),
    .imem_rdata(imem_rdata),
    .imem_resp (imem_resp),
    .id_stall  (id_stall),
    .flush     (flush),
    .if_stall  (if_stall),
    .id_valid  (id_valid),
    .id_pc     (id_pc),
    .id_inst   (id_inst)
  );

  initial forever #5 clk = ~clk;

  function automatic bit exp_stall();
    return rst | flush | (q.size() > 1) | (q.size() > 0 && id_stall) | (m_out && !imem_resp);
  endfunction

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  // reference: q holds delivered instructions oldest-first, q[0] is on id_*
  initial forever begin
    bit   st, del;
    ent_t e;
    @(posedge clk);
    st  = exp_stall();
    del = 0;
    if (rst) begin
      q.delete();
      m_out  = 0;
      m_disc = 0;
    end else begin
      if (m_out && imem_resp) begin
        del   = !m_disc && !flush;
        e     = '{m_pc, imem_rdata};
        m_out = 0;
      end
      if (flush) begin
        q.delete();
        if (m_out) m_disc = 1;
      end else begin
        if (q.size() > 0 && !id_stall) void'(q.pop_front());
        if (del) q.push_back(e);
      end
      if (req_valid && !st) begin
        m_out  = 1;
        m_disc = 0;
        m_pc   = if_id_reg.pc;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    chk("if_stall", {31'b0, if_stall}, {31'b0, exp_stall()});
    chk("id_valid", {31'b0, id_valid}, {31'b0, q.size() > 0});
    if (q.size() > 0) begin
      chk("id_pc", id_pc, q[0].pc);
      chk("id_inst", id_inst, q[0].inst);
    end
  end

  task automatic step(bit r, bit rq, logic [31:0] pc, bit rs, logic [31:0] d, bit st, bit fl);
    rst = r; req_valid = rq; if_id_reg.pc = pc; imem_resp = rs; imem_rdata = d;
    id_stall = st; flush = fl;
    #2 st_seen = if_stall;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    chk("rst_stall", {31'b0, st_seen}, 1);
    chk("rst_valid", {31'b0, id_valid}, 0);
    chk("rst_pc", id_pc, 0);
    chk("rst_inst", id_inst, 0);
    // back-to-back zero-wait
    cnt = 0;
    step(0, 1, 32'h1eceb000, 0, 0, 0, 0);
    cnt += st_seen;
    chk("b2b_n1_valid", {31'b0, id_valid}, 0);
    step(0, 1, 32'h1eceb004, 1, 32'h13, 0, 0);
    cnt += st_seen;
    chk("b2b_first_pc", id_pc, 32'h1eceb000);
    chk("b2b_first_valid", {31'b0, id_valid}, 1);
    step(0, 1, 32'h1eceb008, 1, 32'h13, 0, 0);
    cnt += st_seen;
    chk("b2b_second_pc", id_pc, 32'h1eceb004);
    step(0, 0, 0, 1, 32'h13, 0, 0);
    cnt += st_seen;
    chk("b2b_third_pc", id_pc, 32'h1eceb008);
    chk("b2b_stall_cnt", cnt, 0);
    idle();
    chk("b2b_drain", {31'b0, id_valid}, 0);
    // 3-cycle memory
    cnt = 0;
    step(0, 1, 32'h1eceb000, 0, 0, 0, 0);
    cnt += st_seen;
    step(0, 0, 0, 0, 0, 0, 0);
    cnt += st_seen;
    step(0, 0, 0, 0, 0, 0, 0);
    cnt += st_seen;
    chk("slow_not_yet", {31'b0, id_valid}, 0);
    step(0, 0, 0, 1, 32'h00a00513, 0, 0);
    cnt += st_seen;
    chk("slow_stall_cnt", cnt, 2);
    chk("slow_pc", id_pc, 32'h1eceb000);
    chk("slow_inst", id_inst, 32'h00a00513);
    idle();
    // back-pressure into the skid
    step(0, 1, 32'h1eceb000, 0, 0, 0, 0);
    step(0, 1, 32'h1eceb004, 1, 32'h11111111, 0, 0);
    step(0, 0, 0, 1, 32'h22222222, 1, 0);
    chk("bp_skid_full", {31'b0, dut.skid_valid}, 1);
    step(0, 0, 0, 0, 0, 1, 0);
    chk("bp_stall", {31'b0, st_seen}, 1);
    step(0, 0, 0, 0, 0, 1, 0);
    chk("bp_hold_pc", id_pc, 32'h1eceb000);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("bp_next_pc", id_pc, 32'h1eceb004);
    chk("bp_next_inst", id_inst, 32'h22222222);
    chk("bp_skid_empty", {31'b0, dut.skid_valid}, 0);
    idle();
    chk("bp_no_dup", {31'b0, id_valid}, 0);
    // flush with a 2-cycle fetch in flight
    step(0, 1, 32'h1eceb008, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    chk("fl_state", 32'(dut.state), 32'(FETCH_DISCARD));
    step(0, 1, 32'h1eceb100, 1, 32'hbad00bad, 0, 0);
    chk("fl_dropped", {31'b0, id_valid}, 0);
    step(0, 0, 0, 1, 32'h00100093, 0, 0);
    chk("fl_target_pc", id_pc, 32'h1eceb100);
    chk("fl_target_inst", id_inst, 32'h00100093);
    idle();
    // flush + resp + id_stall together
    step(0, 1, 32'h1eceb200, 0, 0, 0, 0);
    step(0, 1, 32'h1eceb204, 1, 32'h33333333, 0, 0);
    step(0, 0, 0, 1, 32'h44444444, 1, 1);
    chk("co_valid", {31'b0, id_valid}, 0);
    chk("co_skid", {31'b0, dut.skid_valid}, 0);
    chk("co_state", 32'(dut.state), 32'(FETCH_IDLE));
    idle();
    idle();
    chk("co_never", {31'b0, id_valid}, 0);
    // reset mid-fetch then stray response
    step(0, 1, 32'h1eceb300, 0, 0, 0, 0);
    chk("rm_wait", 32'(dut.state), 32'(FETCH_WAIT));
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 32'hffffffff, 0, 0);
    chk("rm_valid", {31'b0, id_valid}, 0);
    chk("rm_pc", id_pc, 0);
    chk("rm_inst", id_inst, 0);
    chk("rm_state", 32'(dut.state), 32'(FETCH_IDLE));
    idle();
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/if_id_buffer.md
# if_id_buffer

Fetch-response buffer and IF/ID pipeline register for the rv32i pipeline, sitting directly downstream of the IF stage and feeding ID. It tracks the single outstanding instruction-memory request, pairs each `imem_rdata` with the PC that requested it, and presents `{pc, inst, valid}` to ID. It absorbs ID back-pressure with a one-entry skid buffer and squashes in-flight fetches on a control-flow flush. Its `if_stall` output tells IF to hold its PC and suppress `imem_rmask`.

## Interface
No parameters; widths are fixed by RV32I.
- `clk`  in  1  — single clock.
- `rst`  in  1  — reset; synchronous, active-high.
- `if_id_reg`  in  `if_id_reg_t`  — IF-side record; `.pc` is the address requested this cycle.
- `req_valid`  in  1  — IF drives a request this cycle (`imem_rmask != 0`).
- `imem_rdata`  in  32  — instruction word; valid only when `imem_resp=1`.
- `imem_resp`  in  1  — memory response strobe, one cycle per request.
- `id_stall`  in  1  — ID cannot accept this cycle.
- `flush`  in  1  — redirect from EX; squash everything younger.
- `if_stall`  out  1  — combinational; IF holds PC and drives `imem_rmask=0`.
- `id_valid`  out  1  — registered; `id_pc`/`id_inst` hold a live instruction.
- `id_pc`  out  32  — registered PC of the presented instruction.
- `id_inst`  out  32  — registered instruction word.

## Operation
- Request acceptance: a request is accepted in a cycle with `req_valid && !if_stall`. The block captures `if_id_reg.pc` into `pend_pc` and enters FETCH_WAIT. At most one request is outstanding.
- FSM states and transitions:
  - FETCH_IDLE: move to WAIT on acceptance. An `imem_resp` seen in IDLE is spurious and ignored.
  - FETCH_WAIT: on `imem_resp`, deliver `{pend_pc, imem_rdata}`. Next state is WAIT if a new request is accepted in the same cycle, otherwise IDLE.
  - FETCH_DISCARD: on `imem_resp`, drop the data. Next state is WAIT if a new request is accepted in the same cycle, otherwise IDLE.
- Delivery priority when data arrives:
  - Goes to the output register if it is empty or being consumed (`id_valid && !id_stall`) and the skid is empty.
  - Otherwise goes to the skid.
- Consumption: when `id_valid && !id_stall`, the output register refills from the skid if the skid is valid, else from the arriving delivery, else becomes empty. Order is always oldest-first.
- Stall equation: `if_stall = rst | flush | skid_valid | (id_valid & id_stall) | (state!=IDLE & !imem_resp)`.
  - Together with the delivery rules, this guarantees the skid never overflows.
- Flush (highest priority, overrides `id_stall`):
  - `id_valid` and `skid_valid` are cleared at the next edge.
  - WAIT without `imem_resp` goes to DISCARD.
  - WAIT with `imem_resp` in the same cycle drops the data and goes to IDLE.
  - DISCARD stays DISCARD until its response arrives.
  - No request is accepted in the flush cycle; IF loads the redirect PC then.
- Reset: state is IDLE, `id_valid=0`, `skid_valid=0`, `id_pc=0`, `id_inst=0`, `pend_pc=0`; `if_stall=1` while `rst` is high.
  - Reset mid-fetch abandons the outstanding request. A response arriving after reset lands in IDLE and is ignored.

## Timing
- With zero-wait memory (request in cycle N, `imem_resp` in N+1), `id_valid` rises in N+2.
  - Steady-state throughput is 1 instruction per cycle with `if_stall` held low.
- With k-cycle memory, `if_stall` is high from N+1 to N+k-1 and `id_valid` rises in N+k+1.
- `id_stall` raised while a response is in flight: the response lands in the skid. `if_stall` goes high the following cycle and stays high until the skid drains.
- After `id_stall` drops, the skid entry appears on `id_*` one cycle later.
- After `flush` in cycle F, `id_valid=0` in F+1. The earliest new request is accepted in F+1 if no response is pending.

## Structure
- Add to `rv32i_types`:
  - `fetch_state_t` enum {FETCH_IDLE, FETCH_WAIT, FETCH_DISCARD}.
  - `fetch_pkt_t` {pc[31:0], inst[31:0], valid}, used for the output register and the skid.
- One sub-module is natural: `fetch_skid`, a one-entry `fetch_pkt_t` holding register with push/pop/clear. Everything else stays flat in `if_id_buffer`.

## Test plan
- Back-to-back fetch: reset, then zero-wait memory returning `0x00000013` for PCs 0x1eceb000, 0x1eceb004, 0x1eceb008 → `id_valid` rises 2 cycles after the first request; `id_pc` steps by 4 each cycle; `if_stall` is never high after reset.
- Slow memory: 3-cycle `imem_resp` for PC 0x1eceb000 → `if_stall` is high for 2 cycles; `id_pc=0x1eceb000` with `id_inst=imem_rdata` appears 4 cycles after the request.
- Back-pressure: `id_stall=1` for 3 cycles while the response for 0x1eceb004 arrives → the skid holds it and `if_stall=1`. After release, `id_pc` shows 0x1eceb000 then 0x1eceb004 with no loss or duplication.
- Flush in flight: `flush` in the cycle after the request for 0x1eceb008 on 2-cycle memory → state DISCARD; the late response is dropped; the first delivered PC is the redirect target 0x1eceb100.
- Coincident events: `flush`, `imem_resp` and `id_stall` all asserted in one cycle → next cycle `id_valid=0`, `skid_valid=0`, state IDLE, and the response data never appears.
- Reset mid-fetch: `rst` during FETCH_WAIT, followed by a stray `imem_resp` → all outputs are zero and the stray response is ignored.
